// File: rtl/svnet_ram_fifo.sv
// svnet_ram_fifo: RAM-backed FIFO; a 3-entry prefetch buffer hides the RAM read pipeline.
// Latency: word accepted at edge N shows on out_valid after edge N+4; 1 word/cycle sustained.
// Backpressure: in_ready drops when RAM holds DEPTH unread words; buffer absorbs in-flight reads.
// Option: define SVNET_RAM_FIFO_AFULL_EN for a registered almost_full (level >= AFULL).

// svnet_ram: simple dual-port storage array with a two-stage registered read path.
// Latency: a write is readable from the next edge; read data is valid two cycles after rd_en.
// Backpressure: none; rd_clr drops any read still travelling through the read pipeline.
module svnet_ram #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_clr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_data_valid
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] s1_data;
  logic             s1_vld;

  // Write port: committed at the edge, visible to a read issued at any later edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read stage 1: array read; the address is free for reuse from this edge on.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      s1_data <= mem[rd_addr];
    end
    s1_vld <= rd_en && !rd_clr;
  end

  // Read stage 2: output register.
  always_ff @(posedge clk) begin
    if (s1_vld) begin
      rd_data <= s1_data;
    end
    rd_data_valid <= s1_vld && !rd_clr;
  end

endmodule

module svnet_ram_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1,
  localparam int LW = $clog2(DEPTH + 4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [LW-1:0] AFULL_C = LW'(AFULL);

  // RAM-side bookkeeping
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] ram_count;       // written, read not yet issued
  logic [CW-1:0] eligible_count;  // subset of ram_count old enough to be read
  logic          wr_pend;         // word written at the last edge, eligible next edge
  logic [1:0]    inflight_count;  // reads issued, data not yet in the buffer

  // prefetch buffer (3-entry circular register FIFO)
  logic [WIDTH-1:0] buf_mem [3];
  logic [1:0]       buf_head;
  logic [1:0]       buf_tail;
  logic [1:0]       buf_count;

  logic [LW-1:0] level_q;
  logic [LW-1:0] level_nxt;

  logic             clr;
  logic             accept;
  logic             pop;
  logic             rd_issue;
  logic             load;
  logic [2:0]       room_used;
  logic             ram_rd_vld;
  logic [WIDTH-1:0] ram_rd_data;

  function automatic logic [1:0] buf_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign clr       = rst || flush;
  assign in_ready  = !clr && (ram_count < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign out_valid = (buf_count != 2'd0);
  assign out_data  = buf_mem[buf_head];
  assign pop       = out_valid && out_ready && !clr;
  assign load      = ram_rd_vld && !clr;

  // Buffer slots already spoken for after this cycle's pop; a new read needs a free one,
  // so every read in flight always has a landing slot even if the consumer stalls.
  assign room_used = 3'(buf_count) + 3'(inflight_count) - 3'(pop);
  assign rd_issue  = !clr && (eligible_count != '0) && (room_used < 3'd3);

  svnet_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk           (clk),
    .wr_en         (accept),
    .wr_addr       (wr_ptr),
    .wr_data       (in_data),
    .rd_en         (rd_issue),
    .rd_addr       (rd_ptr),
    .rd_clr        (clr),
    .rd_data       (ram_rd_data),
    .rd_data_valid (ram_rd_vld)
  );

  // Pointers and occupancy counters for the RAM and the read pipeline.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ram_count      <= '0;
      eligible_count <= '0;
      wr_pend        <= 1'b0;
      inflight_count <= 2'd0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      ram_count      <= ram_count + CW'(accept) - CW'(rd_issue);
      wr_pend        <= accept;
      eligible_count <= eligible_count + CW'(wr_pend) - CW'(rd_issue);
      inflight_count <= inflight_count + 2'(rd_issue) - 2'(load);
    end
  end

  // Prefetch buffer control: push on RAM return, pop on downstream handshake.
  always_ff @(posedge clk) begin
    if (clr) begin
      buf_head  <= 2'd0;
      buf_tail  <= 2'd0;
      buf_count <= 2'd0;
    end else begin
      if (load) begin
        buf_tail <= buf_inc(buf_tail);
      end
      if (pop) begin
        buf_head <= buf_inc(buf_head);
      end
      buf_count <= buf_count + 2'(load) - 2'(pop);
    end
  end

  // Prefetch buffer storage; the head slot is never overwritten while it is presented.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_mem[buf_tail] <= ram_rd_data;
    end
  end

  // Total words held, tracked from the two external handshakes only.
  assign level_nxt = level_q + LW'(accept) - LW'(pop);

  // Level register.
  always_ff @(posedge clk) begin
    if (clr) begin
      level_q <= '0;
    end else begin
      level_q <= level_nxt;
    end
  end

  assign level = level_q;

`ifdef SVNET_RAM_FIFO_AFULL_EN
  logic afull_q;

  // almost_full moves on the same edge as level.
  always_ff @(posedge clk) begin
    if (clr) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (level_nxt >= AFULL_C);
    end
  end

  assign almost_full = afull_q;
`else
  logic [LW-1:0] unused_afull;
  assign unused_afull = AFULL_C;
  assign almost_full  = 1'b0;
`endif

endmodule

// File: tb/tb_svnet_ram_fifo.sv
// tb_svnet_ram_fifo: directed checks of svnet_ram_fifo (WIDTH=8, DEPTH=4, AFULL=3).
// Covers reset, latency, fill/backpressure, throughput across wrap, hold, flush, mid-stream reset.
// almost_full expectations follow SVNET_RAM_FIFO_AFULL_EN as seen by the bench.
module tb_svnet_ram_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 4);

`ifdef SVNET_RAM_FIFO_AFULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;
  logic             almost_full;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  int got;
  int acc_m;
  int pop_m;
  logic             held;
  logic [WIDTH-1:0] hd;
  logic [15:0]      rdy_pat = 16'b1011_0110_0100_1101;

  svnet_ram_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got 0 want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_afull", almost_full, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single word 0xA5: visible exactly 4 edges after acceptance.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_level1", level, 1);
    chk("lat_ov_n0", out_valid, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("lat_ov_early", out_valid, 0);
    end
    @(negedge clk);
    chk("lat_ov", out_valid, 1);
    chk("lat_data", out_data, 8'hA5);
    chk("lat_level_held", level, 1);
    @(negedge clk);
    chk("lat_ov_after_pop", out_valid, 0);
    chk("lat_level0", level, 0);

    // Fill with out_ready low: 4 words in RAM + 3 in buffer, then backpressure.
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("fill_in_ready", in_ready, 1);
      in_valid = 1'b1; in_data = k[7:0];
      @(negedge clk);
      chk("fill_level", level, k + 1);
      chk("fill_afull", almost_full, AF_EN && (k + 1 >= 3));
    end
    in_data = 8'd7;
    for (int k = 0; k < 3; k++) begin
      chk("full_in_ready", in_ready, 0);
      chk("full_level", level, 7);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk("drain_vld", out_valid, 1);
      chk("drain_dat", out_data, i);
      @(negedge clk);
      chk("drain_level", level, 6 - i);
      chk("drain_afull", almost_full, AF_EN && (6 - i >= 3));
    end
    repeat (3) @(negedge clk);
    chk("drain_empty", out_valid, 0);

    // Streaming: 12 words back to back, output one per cycle after the 4-cycle fill.
    for (int m = 1; m <= 17; m++) begin
      in_valid = (m <= 12);
      in_data = 8'h40 + 8'(m - 1);
      if (m <= 12) chk("tp_in_ready", in_ready, 1);
      @(negedge clk);
      acc_m = (m < 12) ? m : 12;
      pop_m = (m <= 5) ? 0 : (((m - 5) < 12) ? (m - 5) : 12);
      chk("tp_level", level, acc_m - pop_m);
      chk("tp_ov", out_valid, (m >= 5) && (m <= 16));
      if ((m >= 5) && (m <= 16)) chk("tp_data", out_data, 8'h40 + 8'(m - 5));
    end
    in_valid = 1'b0;

    // Toggling out_ready: head must hold while stalled; order and count intact.
    got = 0; held = 1'b0; hd = '0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          in_valid = 1'b1; in_data = 8'h80 + 8'(i);
          n = 0;
          while (!in_ready && n < 64) begin @(negedge clk); n++; end
          chk("prod_rdy", in_ready, 1);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 300 && got < 10; c++) begin
          out_ready = rdy_pat[c % 16];
          if (held) begin
            chk("hold_vld", out_valid, 1);
            chk("hold_dat", out_data, hd);
          end
          if (out_valid && out_ready) begin
            chk("rnd_order", out_data, 8'h80 + 8'(got));
            got++;
            held = 1'b0;
          end else begin
            held = out_valid;
            hd = out_data;
          end
          @(negedge clk);
        end
        chk("rnd_count", got, 10);
      end
    join
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rnd_level", level, 0);

    // Flush with level 5 and two reads in flight.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'h10 + 8'(k);
      @(negedge clk);
    end
    chk("pre_flush_level", level, 5);
    chk("pre_flush_ov", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_ov", out_valid, 0);
    chk("flush_afull", almost_full, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_stale", out_valid, 0);
    end
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("flush_ov_early", out_valid, 0);
    end
    @(negedge clk);
    chk("flush_first_vld", out_valid, 1);
    chk("flush_first_dat", out_data, 8'h3C);
    @(negedge clk);
    chk("flush_end_level", level, 0);

    // Reset mid-stream drops everything, no stale word afterwards.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'h51 + 8'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ov", out_valid, 0);
    chk("mrst_level", level, 0);
    chk("mrst_afull", almost_full, 0);
    #1;
    chk("mrst_in_ready_up", in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mrst_stale", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/svnet_ram_fifo.md
SVNET_RAM_FIFO -- requirements
Module: svnet_ram_fifo

Interface
REQ-001 Parameter WIDTH, default 1, data word width in bits.
REQ-002 Parameter DEPTH, default 4, RAM storage words (power of two, >=2).
REQ-003 Parameter AFULL, default DEPTH-1, almost-full threshold on level.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous clear of all stored and in-flight words.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  block accepts word this cycle.
REQ-009 in_data  input  WIDTH  upstream word.
REQ-010 out_valid  output  1  head word present.
REQ-011 out_ready  input  1  downstream consumes head this cycle.
REQ-012 out_data  output  WIDTH  head word.
REQ-013 level  output  $clog2(DEPTH+4)  words held: RAM, in-flight and prefetch buffer.
REQ-014 almost_full  output  1  level >= AFULL (feature-dependent, see Configuration).

Function
REQ-015 Storage SHALL be one internal svnet_ram instance (WIDTH, DEPTH); write-to-read delay 1, read-to-valid delay 2 honoured exactly.
REQ-016 Accept SHALL occur when in_valid && in_ready at a rising edge; the word is written at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-017 in_ready SHALL be 1 iff ram_count < DEPTH and rst=0 and flush=0; ram_count counts words written but not yet read-issued.
REQ-018 A word SHALL become read-eligible 1 cycle after its RAM write is committed (W2R); no read is issued to an address still pending write.
REQ-019 A read SHALL be issued at rd_ptr when eligible_count > 0 and (buffer_count + inflight_count) < 3; rd_ptr increments modulo DEPTH.
REQ-020 Prefetch buffer SHALL be a 3-entry in-order register FIFO, loaded from RAM read_data_valid, sized to absorb all in-flight reads under full backpressure.
REQ-021 out_valid SHALL equal buffer non-empty; out_data SHALL be the buffer head; out_data SHALL be held stable while out_valid && !out_ready.
REQ-022 Pop SHALL occur when out_valid && out_ready at a rising edge.
REQ-023 Empty-FIFO latency SHALL be exactly 4 cycles: a word accepted at edge N makes out_valid=1 after edge N+4.
REQ-024 Sustained throughput SHALL be 1 word/cycle when in_valid and out_ready are held high.
REQ-025 Simultaneous accept and pop SHALL leave level unchanged; simultaneous RAM read-issue and accept at ram_count=DEPTH SHALL NOT occur (in_ready=0).
REQ-026 Pointer wrap-around SHALL be seamless; ordering SHALL be strict FIFO across wrap.
REQ-027 flush SHALL zero all pointers and counters and empty the buffer at that edge; RAM data returning from reads issued before flush SHALL be discarded; in/out handshakes in the flush cycle are ignored.
REQ-028 level SHALL never exceed DEPTH+3; no word SHALL be lost or duplicated.

Reset
REQ-029 While rst=1 (sampled at edge): in_ready=0, out_valid=0, level=0, almost_full=0, pointers/counters cleared, in-flight reads discarded.
REQ-030 in_ready SHALL rise in the first cycle after rst deasserts; RAM contents are not cleared and need not be.
REQ-031 Reset mid-stream SHALL drop all held words; no stale word SHALL appear on out after reset.

Configuration
REQ-032 Macro SVNET_RAM_FIFO_AFULL_EN defined: almost_full registered, equals (level >= AFULL), updated same edge as level.
REQ-033 Macro undefined: almost_full tied to 0, AFULL unused, no comparator logic.

Verification
REQ-034 Reset then one word 0xA5 (WIDTH=8) at edge 10, out_ready=1 -> out_valid high after edge 14 with out_data=0xA5, level 1 then 0.
REQ-035 DEPTH=4, out_ready=0, stream 0..9 -> exactly 7 accepted (4 RAM + 3 buffer), in_ready=0, level=7; then out_ready=1 -> 0..6 in order.
REQ-036 Continuous in_valid/out_ready, 3*DEPTH words -> 1 word/cycle after 4-cycle fill, ordering intact across two pointer wraps.
REQ-037 Random out_ready toggling with data held -> out_data stable whenever out_valid && !out_ready, no loss/duplicates.
REQ-038 flush asserted with 2 reads in flight and level=5 -> level=0 and out_valid=0 next cycle; next accepted word 0x3C is the first word output.
REQ-039 With SVNET_RAM_FIFO_AFULL_EN, DEPTH=4, AFULL=3 -> almost_full rises on edge level reaches 3, falls when it drops to 2; without macro it is 0 throughout.
